arb_rr_lock: RTL and testbench
==============================

ARB_RR_LOCK -- requirements
Module: arb_rr_lock

Interface
REQ-001 SHALL have parameter NPORT, default 5, meaning the number of requesting input ports (legal range 2..16).
REQ-002 SHALL have parameter PRIO_TOP, default 3, meaning the highest-priority port in fixed mode and the reset value of the round-robin pointer (legal range 0..NPORT-1).
REQ-003 SHALL have parameter IW, default $clog2(NPORT), meaning the width of the grant index.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req  input  NPORT  per-port request; bit i high means port i has a flit for this output.
REQ-007 SHALL have port tail  input  NPORT  per-port tail-flit marker; bit i high means port i's current flit ends its packet.
REQ-008 SHALL have port advance  input  1  the downstream output accepted the granted flit this cycle.
REQ-009 SHALL have port mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-010 SHALL have port grt  output  NPORT  registered one-hot grant, all-zero when no owner.
REQ-011 SHALL have port grt_valid  output  1  high when grt is non-zero.
REQ-012 SHALL have port grt_idx  output  IW  binary index of the granted port, 0 when grt_valid is low.

Function
REQ-013 SHALL implement two states: IDLE (no owner) and LOCKED (one owner holds grt).
REQ-014 SHALL, in fixed mode, search ports in the order PRIO_TOP, PRIO_TOP+1, ... wrapping modulo NPORT, and pick the first requesting port.
REQ-015 SHALL, in round-robin mode, use the same wrapping search but start at the pointer ptr instead of PRIO_TOP.
REQ-016 SHALL perform arbitration in any cycle that is IDLE or is a release cycle, and present the winner on grt in the following cycle (one-cycle latency).
REQ-017 SHALL enter LOCKED with the winner as owner when arbitration finds any request; otherwise it SHALL be in IDLE with grt all zero.
REQ-018 SHALL hold grt constant while LOCKED, independent of other ports' requests and of mode changes.
REQ-019 SHALL treat a cycle as a release cycle when LOCKED and advance=1 and tail[owner]=1.
REQ-020 SHALL also treat a cycle as a release cycle (abort) when LOCKED and req[owner]=0, regardless of advance and tail.
REQ-021 SHALL, on every release, set ptr to (owner+1) mod NPORT; ptr SHALL not change in any other cycle.
REQ-022 SHALL include the releasing owner in the release-cycle arbitration if it still requests, so back-to-back packets proceed without a bubble cycle.
REQ-023 SHALL sample mode only in arbitration cycles.
REQ-024 SHALL give the advance-with-tail release priority over a simultaneous abort; both cases have the same result.
REQ-025 SHALL ignore tail and advance when IDLE.
REQ-026 SHALL produce one-hot grt for every NPORT value, including NPORT values that are not a power of two; grt_idx SHALL never exceed NPORT-1.

Reset
REQ-027 SHALL, when rst_=1 at a clock edge, set state=IDLE, grt=0, grt_valid=0, grt_idx=0 and ptr=PRIO_TOP, overriding every other input, including during LOCKED.
REQ-028 SHALL perform its first arbitration in the first cycle with rst_=0 and show that grant in the next cycle.

Verification (NPORT=5, PRIO_TOP=3)
REQ-029 SHALL cover: rst_=1 for 2 cycles with req=5'b11111 -> grt=0 during reset; in the cycle after the first rst_=0 cycle, grt=5'b01000, grt_idx=3.
REQ-030 SHALL cover: mode=0, IDLE, req=5'b00101 -> next cycle grt=5'b00001.
REQ-031 SHALL cover: port 0 owner, req=5'b00011, advance=1, tail=0 for 3 cycles -> grt stays 5'b00001; then tail[0]=1 with advance=1 and req becoming 5'b00010 -> next cycle grt=5'b00010, ptr=1.
REQ-032 SHALL cover: mode=1, req=5'b11111, tail=5'b11111, advance=1 every cycle -> successive grt_idx 3,4,0,1,2,3.
REQ-033 SHALL cover: owner 4 with req dropping to 5'b00100 and tail=0 -> next cycle grt=5'b00100, ptr=0; with req=0 instead -> grt=0, grt_valid=0.
REQ-034 SHALL cover: rst_=1 asserted while LOCKED on port 2 in round-robin mode -> next cycle grt=0 and ptr=3; after release with req=5'b11111, grant is port 3.

Source files
------------

// File: rtl/arb_rr_lock.sv
// Packet-locking arbiter: fixed-priority or round-robin pick among NPORT requesters, grant held until tail or abort.
// Latency: one cycle from an arbitration cycle to the registered grant; back-to-back packets need no bubble.
// Backpressure: advance=0 holds the current owner; a release happens only on advance with tail, or when the owner drops req.
module arb_rr_lock #(
  parameter int NPORT    = 5,
  parameter int PRIO_TOP = 3,
  parameter int IW       = $clog2(NPORT)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             advance,
  input  logic             mode,
  output logic [NPORT-1:0] grt,
  output logic             grt_valid,
  output logic [IW-1:0]    grt_idx
);

  localparam int            IW1  = IW + 1;
  localparam logic [IW-1:0] PTOP = IW'(PRIO_TOP);
  localparam logic [IW-1:0] LAST = IW'(NPORT - 1);
  localparam logic [IW:0]   NP   = IW1'(NPORT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    start;
  logic [IW-1:0]    win;
  logic [IW-1:0]    owner_inc;
  logic [IW-1:0]    idx_n;
  logic [IW:0]      cand;
  logic [NPORT-1:0] grt_n;
  logic             found;
  logic             rel;
  logic             arb;

  // The owner is the registered grant index; its successor is where round-robin resumes after a release.
  assign owner_inc = (grt_idx == LAST) ? '0 : grt_idx + IW'(1);

  // Release on completed tail transfer, or abort when the owner withdraws its request.
  assign rel = (state == LOCKED) && ((advance && tail[grt_idx]) || !req[grt_idx]);
  assign arb = (state == IDLE) || rel;

  assign grt_valid = |grt;

  // Search start: fixed top port, or the round-robin pointer (already advanced past a releasing owner).
  always_comb begin
    if (!mode)    start = PTOP;
    else if (rel) start = owner_inc;
    else          start = ptr;
  end

  // Wrapping search from start; the first requesting port wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand = {1'b0, start} + IW1'(k);
      if (cand >= NP) cand = cand - NP;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // Next-state and next-grant: grant only changes in arbitration cycles, pointer only on release.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grt_n   = grt;
    idx_n   = grt_idx;
    if (rel) ptr_n = owner_inc;
    if (arb) begin
      grt_n = '0;
      if (found) begin
        state_n    = LOCKED;
        grt_n[win] = 1'b1;
        idx_n      = win;
      end else begin
        state_n = IDLE;
        idx_n   = '0;
      end
    end
  end

  // State, pointer and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state   <= IDLE;
      ptr     <= PTOP;
      grt     <= '0;
      grt_idx <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      grt     <= grt_n;
      grt_idx <= idx_n;
    end
  end

endmodule

// File: tb/tb_arb_rr_lock.sv
// Self-checking bench for arb_rr_lock: directed scenarios then randomized traffic against a packet-level model.
// The model tracks owner port and round-robin pointer as plain integers.
// All comparisons go through chk; one summary line at the end.
module tb_arb_rr_lock;
  localparam int N  = 5;
  localparam int PT = 3;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  tail = '0;
  logic          advance = 1'b0;
  logic          mode = 1'b0;
  logic [N-1:0]  grt;
  logic          grt_valid;
  logic [IW-1:0] grt_idx;

  int checks = 0;
  int errors = 0;
  int m_owner = -1;
  int m_ptr = PT;

  always #5 clk = ~clk;

  arb_rr_lock #(.NPORT(N), .PRIO_TOP(PT), .IW(IW)) dut (
    .clk(clk), .rst_(rst_), .req(req), .tail(tail), .advance(advance), .mode(mode),
    .grt(grt), .grt_valid(grt_valid), .grt_idx(grt_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Packet-level reference: who owns the output after this clock edge.
  task automatic model_edge();
    bit relse;
    int start;
    if (rst_) begin
      m_owner = -1;
      m_ptr   = PT;
    end else begin
      relse = (m_owner >= 0) && ((advance && tail[m_owner]) || !req[m_owner]);
      if (m_owner < 0 || relse) begin
        if (relse) m_ptr = (m_owner + 1) % N;
        start   = mode ? m_ptr : PT;
        m_owner = -1;
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(start + k) % N]) m_owner = (start + k) % N;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl,
                     input logic adv, input logic md);
    logic [31:0] eg;
    rst_ = r; req = rq; tail = tl; advance = adv; mode = md;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("grt", {27'd0, grt}, eg);
    chk("grt_valid", {31'd0, grt_valid}, (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("grt_idx", {29'd0, grt_idx}, (m_owner < 0) ? 32'd0 : m_owner);
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{3, 4, 0, 1, 2, 3};

    // Reset with everyone requesting, then first grant goes to PRIO_TOP.
    cyc(1'b1, 5'b11111, '0, 1'b0, 1'b0);
    chk("rst_grt0", {27'd0, grt}, 32'd0);
    cyc(1'b1, 5'b11111, '0, 1'b0, 1'b0);
    chk("rst_grt1", {27'd0, grt}, 32'd0);
    cyc(1'b0, 5'b11111, '0, 1'b0, 1'b0);
    chk("first_grt", {27'd0, grt}, 32'b01000);
    chk("first_idx", {29'd0, grt_idx}, 32'd3);

    // Fixed priority wraps past the top port.
    cyc(1'b1, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 5'b00101, '0, 1'b0, 1'b0);
    chk("fixed_wrap", {27'd0, grt}, 32'b00001);

    // Owner held across non-tail transfers, then tail hands over without a bubble.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'b00011, 5'b00000, 1'b1, 1'b0);
      chk("hold", {27'd0, grt}, 32'b00001);
    end
    cyc(1'b0, 5'b00010, 5'b00001, 1'b1, 1'b0);
    chk("tail_handover", {27'd0, grt}, 32'b00010);
    // Pointer now 1: round-robin release of port 1 continues at port 2.
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1);
    chk("ptr_after_tail", {29'd0, grt_idx}, 32'd2);

    // Round-robin rotation with every packet a single flit.
    cyc(1'b1, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1);
      chk("rr_seq", {29'd0, grt_idx}, exp_seq[i]);
    end
    cyc(1'b0, 5'b11111, 5'b11111, 1'b1, 1'b1);
    chk("rr_owner4", {29'd0, grt_idx}, 32'd4);

    // Abort from owner 4: pointer goes to 0, port 2 is next.
    cyc(1'b0, 5'b00100, 5'b00000, 1'b0, 1'b1);
    chk("abort_grt", {27'd0, grt}, 32'b00100);

    // Abort from owner 4 with nobody requesting leaves the output idle.
    cyc(1'b1, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, 5'b10000, '0, 1'b0, 1'b1);
    chk("own4", {27'd0, grt}, 32'b10000);
    cyc(1'b0, 5'b00000, '0, 1'b0, 1'b1);
    chk("abort_idle", {27'd0, grt}, 32'd0);
    chk("abort_idle_vld", {31'd0, grt_valid}, 32'd0);

    // Reset while locked on port 2 restores the pointer to PRIO_TOP.
    cyc(1'b0, 5'b00100, '0, 1'b0, 1'b1);
    chk("own2", {27'd0, grt}, 32'b00100);
    cyc(1'b1, 5'b00100, '0, 1'b1, 1'b1);
    chk("rst_locked", {27'd0, grt}, 32'd0);
    cyc(1'b0, 5'b11111, '0, 1'b0, 1'b1);
    chk("rst_ptr", {29'd0, grt_idx}, 32'd3);

    // Randomized traffic, including mode flips and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] rq;
      rq = N'($urandom);
      if ($urandom_range(0, 3) == 0) rq = rq | N'($urandom);
      cyc(($urandom_range(0, 60) == 0), rq, N'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
